clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 168 ++++++++++++++++
 tb/tb_clk_div_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Measures high/low phase lengths of an asynchronous divided clock in clk cycles,
// checks period and duty cycle against tolerances, and flags a stuck clock.
module clk_div_monitor #(
    parameter int CNT_W   = 16,
    parameter int TOL     = 1,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_div_clk_in,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_exp_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic [CNT_W-1:0] o_low_time,
    output logic [CNT_W:0]   o_period,
    output logic             o_meas_valid,
    output logic             o_period_ok,
    output logic             o_duty_ok,
    output logic             o_stuck
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_D = CNT_W'(TOL);
    localparam logic [CNT_W:0]   TOL_P = (CNT_W+1)'(TOL);

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_s, r_s_d;
    logic [2:0]       r_prime;
    logic [CNT_W-1:0] r_hi_cnt, r_lo_cnt, r_wait_cnt;
    logic [CNT_W-1:0] w_hi_nxt, w_lo_nxt, w_wait_nxt;
    logic [CNT_W-1:0] w_hi_inc, w_lo_inc, w_wait_inc;
    logic             w_rise, w_fall, w_latch, w_timeout;
    logic [CNT_W:0]   w_sum, w_exp_ext, w_pdiff;
    logic [CNT_W-1:0] w_ddiff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Edges are trusted only once s and s_d both hold real samples, so the
    // synchronizer filling after reset can never fake a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_s_d   <= 1'b0;
            r_prime <= '0;
        end else begin
            r_sync1 <= i_div_clk_in;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
            r_prime <= {r_prime[1:0], 1'b1};
        end
    end

    assign w_rise     = r_prime[2] & r_s & ~r_s_d;
    assign w_fall     = r_prime[2] & ~r_s & r_s_d;
    assign w_hi_inc   = sat_inc(r_hi_cnt);
    assign w_lo_inc   = sat_inc(r_lo_cnt);
    assign w_wait_inc = sat_inc(r_wait_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi_cnt;
        w_lo_nxt    = r_lo_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_latch     = 1'b0;
        w_timeout   = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_hi_nxt    = '0;
            w_lo_nxt    = '0;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_RISE;
                    w_hi_nxt    = '0;
                    w_lo_nxt    = '0;
                    w_wait_nxt  = '0;
                end
                WAIT_RISE: begin
                    if (w_rise) begin
                        w_state_nxt = MEAS_HIGH;
                        w_hi_nxt    = CNT_W'(1);
                        w_wait_nxt  = '0;
                    end else if (w_wait_inc >= TO_V) begin
                        w_timeout  = 1'b1;
                        w_wait_nxt = '0;
                    end else begin
                        w_wait_nxt = w_wait_inc;
                    end
                end
                MEAS_HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = MEAS_LOW;
                        w_lo_nxt    = CNT_W'(1);
                    end else if (w_hi_inc >= TO_V) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = WAIT_RISE;
                        w_hi_nxt    = '0;
                        w_lo_nxt    = '0;
                    end else begin
                        w_hi_nxt = w_hi_inc;
                    end
                end
                MEAS_LOW: begin
                    if (w_rise) begin
                        w_latch     = 1'b1;
                        w_state_nxt = MEAS_HIGH;
                        w_hi_nxt    = CNT_W'(1);
                        w_lo_nxt    = '0;
                    end else if (w_lo_inc >= TO_V) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = WAIT_RISE;
                        w_hi_nxt    = '0;
                        w_lo_nxt    = '0;
                    end else begin
                        w_lo_nxt = w_lo_inc;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_sum     = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
    assign w_exp_ext = {1'b0, i_exp_period};
    assign w_pdiff   = (w_sum >= w_exp_ext) ? w_sum - w_exp_ext : w_exp_ext - w_sum;
    assign w_ddiff   = (r_hi_cnt >= r_lo_cnt) ? r_hi_cnt - r_lo_cnt : r_lo_cnt - r_hi_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt     <= '0;
            r_lo_cnt     <= '0;
            r_wait_cnt   <= '0;
            o_high_time  <= '0;
            o_low_time   <= '0;
            o_period     <= '0;
            o_meas_valid <= 1'b0;
            o_period_ok  <= 1'b0;
            o_duty_ok    <= 1'b0;
            o_stuck      <= 1'b0;
        end else begin
            r_hi_cnt     <= w_hi_nxt;
            r_lo_cnt     <= w_lo_nxt;
            r_wait_cnt   <= w_wait_nxt;
            o_meas_valid <= w_latch;
            if (w_latch) begin
                o_high_time <= r_hi_cnt;
                o_low_time  <= r_lo_cnt;
                o_period    <= w_sum;
                o_period_ok <= (w_pdiff <= TOL_P);
                o_duty_ok   <= (w_ddiff <= TOL_D);
            end
            if (!i_en || w_latch) o_stuck <= 1'b0;
            else if (w_timeout)   o_stuck <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a pattern generator drives the divided
// clock, expected results are queued per scenario and popped on each meas_valid.
module tb_clk_div_monitor;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] lo;
        logic [CNT_W:0]   per;
        logic             pok;
        logic             dok;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_div_clk_in;
    logic             i_en;
    logic [CNT_W-1:0] i_exp_period;
    logic [CNT_W-1:0] o_high_time, o_low_time;
    logic [CNT_W:0]   o_period;
    logic             o_meas_valid, o_period_ok, o_duty_ok, o_stuck;

    int   tests = 0, fails = 0, vcnt = 0;
    bit   gen_on = 0, gen_idle = 0, idle_lvl = 0;
    int   hi_len = 3, lo_len = 3;
    res_t sb[$];

    clk_div_monitor #(.CNT_W(CNT_W), .TOL(1), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .i_div_clk_in(i_div_clk_in), .i_en(i_en),
        .i_exp_period(i_exp_period), .o_high_time(o_high_time), .o_low_time(o_low_time),
        .o_period(o_period), .o_meas_valid(o_meas_valid), .o_period_ok(o_period_ok),
        .o_duty_ok(o_duty_ok), .o_stuck(o_stuck)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_meas_valid) vcnt <= vcnt + 1;

    // Divided-clock generator, changes 1 time unit after the clk edge.
    initial begin
        i_div_clk_in = 1'b0;
        forever begin
            if (gen_on) begin
                gen_idle = 0;
                i_div_clk_in = 1'b1;
                repeat (hi_len) begin @(posedge clk); #1; end
                i_div_clk_in = 1'b0;
                repeat (lo_len) begin @(posedge clk); #1; end
            end else begin
                gen_idle = 1;
                i_div_clk_in = idle_lvl;
                @(posedge clk); #1;
            end
        end
    end

    function automatic res_t mk(input int h, input int l, input int e);
        res_t r;
        int   p = h + l;
        r.hi  = CNT_W'(h);
        r.lo  = CNT_W'(l);
        r.per = (CNT_W+1)'(p);
        r.pok = ((p > e) ? p - e : e - p) <= 1;
        r.dok = ((h > l) ? h - l : l - h) <= 1;
        return r;
    endfunction

    function automatic res_t cur();
        return '{o_high_time, o_low_time, o_period, o_period_ok, o_duty_ok};
    endfunction

    task automatic wait_valid(input int bound, output bit got);
        got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_meas_valid) begin got = 1; break; end
        end
    endtask

    task automatic start_pattern(input int h, input int l, input int e);
        i_en = 1'b0;
        hi_len = h; lo_len = l; idle_lvl = 0; gen_on = 1;
        i_exp_period = CNT_W'(e);
        repeat (20) @(negedge clk);
        i_en = 1'b1;
    endtask

    task automatic drain(input string name, input int n);
        bit   got;
        res_t e;
        for (int k = 0; k < n; k++) begin
            wait_valid(40, got);
            e = sb.pop_front();
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL %s[%0d]: no meas_valid within 40 cycles, expected %h", name, k, e);
            end else if (cur() !== e) begin
                fails++;
                $display("FAIL %s[%0d]: got %h expected %h", name, k, cur(), e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_en = 1'b0; i_exp_period = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({cur(), o_meas_valid, o_stuck} !== '0) begin
            fails++;
            $display("FAIL reset: got %h expected 0", {cur(), o_meas_valid, o_stuck});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_div6();
        start_pattern(3, 3, 6);
        repeat (3) sb.push_back(mk(3, 3, 6));
        drain("div6", 3);
    endtask

    task automatic test_skew();
        start_pattern(4, 2, 6);
        repeat (2) sb.push_back(mk(4, 2, 6));
        drain("skew", 2);
    endtask

    task automatic test_div3();
        start_pattern(2, 1, 4);
        repeat (2) sb.push_back(mk(2, 1, 4));
        drain("div3_exp4", 2);
        i_exp_period = CNT_W'(5);
        repeat (2) sb.push_back(mk(2, 1, 5));
        drain("div3_exp5", 2);
    endtask

    task automatic test_stuck();
        bit got;
        int base;
        start_pattern(3, 3, 6);
        sb.push_back(mk(3, 3, 6));
        drain("stuck_pre", 1);
        idle_lvl = 1; gen_on = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = gen_idle; end
        tests++;
        if (!got) begin fails++; $display("FAIL stuck_gen_idle: got 0 expected 1"); end
        repeat (6) @(negedge clk);
        #1 base = vcnt;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = o_stuck; end
        tests++;
        if (!got) begin fails++; $display("FAIL stuck_set: stuck %0b expected 1", o_stuck); end
        repeat (25) @(negedge clk);
        #1;
        tests++;
        if ({vcnt - base, o_stuck} !== {32'd0, 1'b1}) begin
            fails++;
            $display("FAIL stuck_hold: extra valids %0d stuck %0b expected 0 and 1", vcnt - base, o_stuck);
        end
        hi_len = 3; lo_len = 3; gen_on = 1;
        sb.push_back(mk(3, 3, 6));
        drain("stuck_recover", 1);
        tests++;
        if (o_stuck !== 1'b0) begin
            fails++;
            $display("FAIL stuck_clear: stuck %0b expected 0 at meas_valid", o_stuck);
        end
    endtask

    task automatic test_en_abort();
        int   base;
        res_t held;
        start_pattern(3, 3, 6);
        held = mk(3, 3, 6);
        sb.push_back(held);
        drain("abort_pre", 1);
        repeat (5) @(negedge clk);
        i_en = 1'b0;
        #1 base = vcnt;
        repeat (12) @(negedge clk);
        #1;
        tests++;
        if (vcnt != base) begin
            fails++;
            $display("FAIL abort_valid: got %0d valids expected 0", vcnt - base);
        end
        tests++;
        if (cur() !== held) begin
            fails++;
            $display("FAIL abort_hold: got %h expected %h", cur(), held);
        end
    endtask

    task automatic test_reset_mid();
        start_pattern(2, 2, 4);
        sb.push_back(mk(2, 2, 4));
        drain("rstmid_pre", 1);
        hi_len = 3; lo_len = 3; i_exp_period = CNT_W'(6);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cur(), o_meas_valid, o_stuck} !== '0) begin
            fails++;
            $display("FAIL rstmid_zero: got %h expected 0", {cur(), o_meas_valid, o_stuck});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(3, 3, 6));
        drain("rstmid_first", 1);
    endtask

    initial begin
        test_reset();
        test_div6();
        test_skew();
        test_div3();
        test_stuck();
        test_en_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
